// File: rtl/tick_timer_ctrl.sv
// Down-count timer clocked by prescaler max_tick strobes.
// One-shot/periodic modes, pause/resume/abort and sticky irq/overrun flags.
module tick_timer_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [WIDTH-1:0] load_val,
  input  logic             irq_clr,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             paused,
  output logic             done,
  output logic             irq,
  output logic             overrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             r_done;
  logic             r_irq;
  logic             r_ovr;
  logic             w_expire;
  logic             w_lv_zero;
  logic             w_last;

  assign w_lv_zero = (load_val == '0);
  // count is never 0 in RUN, so <=1 only matches the expiry tick
  assign w_last    = (r_count <= WIDTH'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_expire    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          if (w_lv_zero) begin
            w_expire = 1'b1;
          end else begin
            w_count_nxt = load_val;
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (stop) begin
          w_state_nxt = S_PAUSE;
        end else if (start) begin
          if (w_lv_zero) begin
            w_expire    = 1'b1;
            w_count_nxt = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_count_nxt = load_val;
          end
        end else if (tick) begin
          if (!w_last) begin
            w_count_nxt = r_count - WIDTH'(1);
          end else begin
            w_expire = 1'b1;
            if (periodic && !w_lv_zero) begin
              w_count_nxt = load_val;
            end else begin
              w_count_nxt = '0;
              w_state_nxt = S_IDLE;
            end
          end
        end
      end
      S_PAUSE: begin
        if (stop) begin
          w_count_nxt = '0;
          w_state_nxt = S_IDLE;
        end else if (start) begin
          w_state_nxt = S_RUN;
        end
      end
      default: begin
        w_count_nxt = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Expiry beats a coincident clear for irq; a clear suppresses overrun
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done <= 1'b0;
      r_irq  <= 1'b0;
      r_ovr  <= 1'b0;
    end else begin
      r_done <= w_expire;
      if (w_expire) begin
        r_irq <= 1'b1;
      end else if (irq_clr) begin
        r_irq <= 1'b0;
      end
      if (w_expire && r_irq && !irq_clr) begin
        r_ovr <= 1'b1;
      end else if (irq_clr) begin
        r_ovr <= 1'b0;
      end
    end
  end

  assign count   = r_count;
  assign busy    = (r_state != S_IDLE);
  assign paused  = (r_state == S_PAUSE);
  assign done    = r_done;
  assign irq     = r_irq;
  assign overrun = r_ovr;

endmodule

// File: tb/tb_tick_timer_ctrl.sv
// Bench for tick_timer_ctrl: directed scenarios plus random
// traffic, every cycle compared against a behavioural model.
module tb_tick_timer_ctrl;

  logic        clk;
  logic        reset;
  logic        tick;
  logic        start;
  logic        stop;
  logic        periodic;
  logic [15:0] load_val;
  logic        irq_clr;
  logic [15:0] count;
  logic        busy;
  logic        paused;
  logic        done;
  logic        irq;
  logic        overrun;

  int n_checks = 0;
  int n_errors = 0;

  // model: mode 0=idle 1=run 2=pause
  int m_mode;
  int m_cnt;
  bit m_done;
  bit m_irq;
  bit m_ovr;

  tick_timer_ctrl #(.WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .tick     (tick),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .load_val (load_val),
    .irq_clr  (irq_clr),
    .count    (count),
    .busy     (busy),
    .paused   (paused),
    .done     (done),
    .irq      (irq),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0;
    m_cnt  = 0;
    m_done = 0;
    m_irq  = 0;
    m_ovr  = 0;
  endfunction

  function automatic void model_step();
    bit ex;
    int lv;
    ex = 0;
    lv = int'(load_val);
    if (reset) begin
      model_reset();
      return;
    end
    if (m_mode == 0) begin
      if (start && !stop) begin
        if (lv == 0) ex = 1;
        else begin
          m_cnt  = lv;
          m_mode = 1;
        end
      end
    end else if (m_mode == 1) begin
      if (stop) m_mode = 2;
      else if (start) begin
        if (lv == 0) begin
          ex = 1;
          m_cnt = 0;
          m_mode = 0;
        end else m_cnt = lv;
      end else if (tick) begin
        if (m_cnt > 1) m_cnt = m_cnt - 1;
        else begin
          ex = 1;
          if (periodic && lv != 0) m_cnt = lv;
          else begin
            m_cnt = 0;
            m_mode = 0;
          end
        end
      end
    end else begin
      if (stop) begin
        m_cnt = 0;
        m_mode = 0;
      end else if (start) m_mode = 1;
    end
    if (ex && m_irq && !irq_clr) m_ovr = 1;
    else if (irq_clr) m_ovr = 0;
    if (ex) m_irq = 1;
    else if (irq_clr) m_irq = 0;
    m_done = ex;
  endfunction

  task automatic compare_all();
    check("count", {16'h0, count}, m_cnt);
    check("flags", {27'h0, busy, paused, done, irq, overrun},
          {27'h0, m_mode != 0, m_mode == 2, m_done, m_irq, m_ovr});
  endtask

  task automatic cyc(input bit st, input bit sp,
                     input bit tk, input bit clr = 0);
    start   = st;
    stop    = sp;
    tick    = tk;
    irq_clr = clr;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    start   = 0;
    stop    = 0;
    tick    = 0;
    irq_clr = 0;
  endtask

  task automatic ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      repeat (gap - 1) cyc(0, 0, 0);
      cyc(0, 0, 1);
    end
  endtask

  initial begin
    reset    = 1;
    tick     = 0;
    start    = 0;
    stop     = 0;
    periodic = 0;
    load_val = 16'd5;
    irq_clr  = 0;
    model_reset();

    // reset held: start/tick have no effect
    cyc(1, 0, 1);
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    reset = 0;
    repeat (5) cyc(0, 0, 1);
    check("idle_cnt", {16'h0, count}, 0);
    check("idle_busy", {31'h0, busy}, 0);

    // one-shot
    load_val = 16'd3;
    periodic = 0;
    cyc(1, 0, 0);
    check("os_load", {16'h0, count}, 3);
    ticks(3, 10);
    check("os_done", {31'h0, done}, 1);
    check("os_busy", {31'h0, busy}, 0);
    check("os_irq", {31'h0, irq}, 1);
    cyc(0, 0, 0, 1);

    // periodic with overrun
    load_val = 16'd4;
    periodic = 1;
    cyc(1, 0, 0);
    ticks(4, 3);
    check("per_d4", {31'h0, done}, 1);
    ticks(4, 3);
    check("per_ovr", {31'h0, overrun}, 1);
    ticks(4, 3);
    check("per_d12", {31'h0, done}, 1);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0, 1);
    check("per_clr", {30'h0, irq, overrun}, 0);

    // pause / resume / abort
    load_val = 16'd5;
    periodic = 0;
    cyc(1, 0, 0);
    ticks(2, 4);
    check("pr_cnt", {16'h0, count}, 3);
    cyc(0, 1, 0);
    check("pr_paused", {31'h0, paused}, 1);
    ticks(3, 2);
    check("pr_frozen", {16'h0, count}, 3);
    cyc(1, 0, 0);
    ticks(3, 4);
    check("pr_done", {31'h0, done}, 1);
    cyc(1, 0, 0);
    ticks(2, 4);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    check("abort", {15'h0, count, busy, done}, 0);

    // collisions
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    check("ss_pause", {31'h0, paused}, 1);
    cyc(1, 0, 0);
    load_val = 16'd4;
    cyc(1, 0, 0);
    ticks(2, 2);
    cyc(1, 0, 1);
    check("tk_start", {16'h0, count}, 4);
    ticks(3, 1);
    cyc(0, 0, 1, 1);
    check("exp_clr", {30'h0, irq, overrun}, 2);

    // edge values
    load_val = 16'd0;
    cyc(1, 0, 0);
    check("lv0_done", {30'h0, done, busy}, 2);
    cyc(0, 0, 0);
    check("lv0_once", {31'h0, done}, 0);
    load_val = 16'hFFFF;
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    check("max_cnt", {16'h0, count}, 32'hFFFE);

    // asynchronous reset mid-run
    load_val = 16'd4;
    cyc(1, 0, 0);
    ticks(2, 2);
    #2 reset = 1;
    #1;
    check("arst", {10'h0, count, busy, paused, done, irq, overrun}, 0);
    model_reset();
    cyc(0, 0, 0);
    reset = 0;
    cyc(0, 0, 1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        periodic = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 19) == 0) load_val = 16'($urandom);
        else load_val = 16'($urandom_range(0, 7));
      end
      cyc($urandom_range(0, 39) == 0,
          $urandom_range(0, 59) == 0,
          $urandom_range(0, 2) == 0,
          $urandom_range(0, 29) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
